// File: rtl/wishbone_memory_slave.sv
// Wishbone single-transfer memory responder with byte lanes and a fixed wait-state count.
// Accepted requests are latched, then acked after WAIT_STATES cycles unless aborted or reset.
module wishbone_memory_slave #(
    parameter int unsigned WORD        = 16,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cyc_i,
    input  logic                   stb_i,
    input  logic                   we_i,
    input  logic [WORD/8-1:0]      sel_i,
    input  logic [WORD-(WORD/8):0] adr_i,
    input  logic [WORD-1:0]        dat_i,
    output logic [WORD-1:0]        dat_o,
    output logic                   ack_o
);

    localparam int unsigned LANES = WORD / 8;
    localparam int unsigned AW    = WORD - LANES + 1;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e           r_state;
    logic [3:0]       r_cnt;
    logic             r_we;
    logic [LANES-1:0] r_sel;
    logic [AW-1:0]    r_adr;
    logic [WORD-1:0]  r_dat;
    logic [WORD-1:0]  r_mem [DEPTH];

    logic             w_req;
    logic             w_enter_ack;
    logic             w_we;
    logic             w_in_range;
    logic [LANES-1:0] w_sel;
    logic [AW-1:0]    w_adr;
    logic [WORD-1:0]  w_dat;
    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        w_req       = cyc_i & stb_i;
        w_enter_ack = ~rst_i & (((r_state == StIdle) & w_req & (WAIT_STATES == 0)) |
                                ((r_state == StWait) & w_req & (r_cnt == 4'd1)));
        // With zero wait states ACK is entered on the accept edge itself, so use live inputs.
        w_we        = (r_state == StIdle) ? we_i  : r_we;
        w_sel       = (r_state == StIdle) ? sel_i : r_sel;
        w_adr       = (r_state == StIdle) ? adr_i : r_adr;
        w_dat       = (r_state == StIdle) ? dat_i : r_dat;
        w_off       = 32'(w_adr) - BASE_ADDR;
        w_in_range  = (32'(w_adr) >= BASE_ADDR) && (w_off < DEPTH);
        w_idx       = w_off[IDX_W-1:0];
    end

    // Array has no reset so it can map onto a RAM macro.
    always_ff @(posedge clk_i) begin
        if (w_enter_ack && w_we && w_in_range) begin
            for (int b = 0; b < LANES; b++) begin
                if (w_sel[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_dat[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            ack_o   <= 1'b0;
            dat_o   <= '0;
        end else begin
            ack_o <= w_enter_ack;
            if (w_enter_ack && !w_we) begin
                dat_o <= w_in_range ? r_mem[w_idx] : '0;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_we  <= we_i;
                        r_sel <= sel_i;
                        r_adr <= adr_i;
                        r_dat <= dat_i;
                        if (WAIT_STATES == 0) begin
                            r_state <= StAck;
                        end else begin
                            r_cnt   <= 4'(WAIT_STATES);
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (!w_req) begin
                        r_cnt   <= 4'd0;
                        r_state <= StIdle;
                    end else if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= StAck;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StAck:   r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_memory_slave.sv
// Randomized bench for wishbone_memory_slave against a word/lane array model.
// Covers latency, byte lanes, address decode, abort, reset abandon and back-to-back strobes.
module tb_wishbone_memory_slave;

    localparam int unsigned WORD  = 16;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned BASE  = 32'h100;
    localparam int unsigned WS    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [14:0] adr = '0;
    logic [15:0] dat = '0;
    logic [15:0] dat_o;
    logic        ack_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] model_mem   [DEPTH];
    logic [1:0]  model_known [DEPTH];
    logic [15:0] last_exp;
    logic [15:0] last_mask;

    wishbone_memory_slave #(
        .WORD       (WORD),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(WS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cyc_i(cyc),
        .stb_i(stb),
        .we_i (we),
        .sel_i(sel),
        .adr_i(adr),
        .dat_i(dat),
        .dat_o(dat_o),
        .ack_o(ack_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [14:0] a);
        int unsigned ai = 32'(a);
        return (ai >= BASE) && ((ai - BASE) < DEPTH);
    endfunction

    function automatic logic [15:0] lane_mask(input logic [1:0] s);
        return {{8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic model_write(input logic [14:0] a, input logic [15:0] d, input logic [1:0] s);
        int unsigned i;
        logic [15:0] m;
        if (in_range(a)) begin
            i = 32'(a) - BASE;
            m = lane_mask(s);
            model_mem[i]   = (model_mem[i] & ~m) | (d & m);
            model_known[i] = model_known[i] | s;
        end
    endtask

    // Single transfer; bus inputs are scrambled after accept to prove they are latched.
    task automatic bus(input logic w, input logic [14:0] a, input logic [15:0] d,
                       input logic [1:0] s);
        int k;
        logic [15:0] rd;
        logic [15:0] exp;
        logic [15:0] m;
        int unsigned i;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        @(posedge clk);
        #1;
        we = 1'($urandom); adr = 15'($urandom); dat = 16'($urandom); sel = 2'($urandom);
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack_o) break;
        end
        rd  = dat_o;
        cyc = 1'b0; stb = 1'b0;
        check_val("latency", 32'(k), 32'(1 + WS));
        @(negedge clk);
        check_val("ack_pulse", 32'(ack_o), 32'd0);
        if (w) begin
            model_write(a, d, s);
            check_val("hold", 32'(dat_o & last_mask), 32'(last_exp & last_mask));
        end else begin
            if (in_range(a)) begin
                i   = 32'(a) - BASE;
                exp = model_mem[i];
                m   = lane_mask(model_known[i]);
            end else begin
                exp = 16'h0000;
                m   = 16'hFFFF;
            end
            if (m != 16'h0000) check_val("read", 32'(rd & m), 32'(exp & m));
            last_exp  = exp;
            last_mask = m;
        end
    endtask

    task automatic read_expect(input logic [14:0] a, input logic [15:0] exp, input string tag);
        bus(1'b0, a, 16'h0, 2'b11);
        check_val(tag, 32'(last_exp), 32'(exp));
    endtask

    initial begin
        int acks;
        int first_ack;
        int second_ack;
        int consec;
        logic prev_ack;
        logic [15:0] b2b_rd;
        logic [14:0] ra;
        logic [14:0] edges [6];

        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = 16'h0;
            model_known[i] = 2'b00;
        end
        last_exp  = 16'h0;
        last_mask = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("reset_ack", 32'(ack_o), 32'd0);
        check_val("reset_dat", 32'(dat_o), 32'd0);

        // Full write then readback.
        bus(1'b1, 15'h110, 16'hBEEF, 2'b11);
        read_expect(15'h110, 16'hBEEF, "wr_rd_beef");

        // Byte-lane merge.
        bus(1'b1, 15'h120, 16'h1234, 2'b11);
        bus(1'b1, 15'h120, 16'hAACD, 2'b01);
        read_expect(15'h120, 16'h12CD, "lane_lo");
        bus(1'b1, 15'h120, 16'h56FF, 2'b10);
        read_expect(15'h120, 16'h56CD, "lane_hi");
        bus(1'b1, 15'h120, 16'h9999, 2'b00);
        read_expect(15'h120, 16'h56CD, "lane_none");

        // Out-of-range decode on both sides of the window.
        bus(1'b1, 15'h0FF, 16'h7777, 2'b11);
        bus(1'b1, 15'h500, 16'h8888, 2'b11);
        read_expect(15'h0FF, 16'h0000, "oor_low");
        read_expect(15'h500, 16'h0000, "oor_high");
        bus(1'b1, 15'h4FF, 16'hC0DE, 2'b11);
        read_expect(15'h4FF, 16'hC0DE, "last_word");

        // Strobe dropped in each wait cycle.
        bus(1'b1, 15'h130, 16'h3030, 2'b11);
        for (int d = 1; d <= WS; d++) begin
            @(negedge clk);
            cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 15'h130; dat = 16'hDEAD; sel = 2'b11;
            @(posedge clk);
            acks = 0;
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                if (ack_o) acks++;
                if (n == d) stb = 1'b0;
            end
            cyc = 1'b0;
            check_val("abort_ack", 32'(acks), 32'd0);
            read_expect(15'h130, 16'h3030, "abort_mem");
        end

        // Reset during wait abandons the write.
        bus(1'b1, 15'h140, 16'h1111, 2'b11);
        bus(1'b1, 15'h141, 16'h2222, 2'b11);
        read_expect(15'h141, 16'h2222, "pre_reset_rd");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 15'h140; dat = 16'h5A5A; sel = 2'b11;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_ack", 32'(ack_o), 32'd0);
        check_val("rst_dat", 32'(dat_o), 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack_o) acks++;
        end
        check_val("rst_no_ack", 32'(acks), 32'd0);
        last_exp  = 16'h0;
        last_mask = 16'hFFFF;
        read_expect(15'h140, 16'h1111, "rst_mem");
        read_expect(15'h141, 16'h2222, "rst_prior");

        // Strobe held across a read then a write.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 15'h110; dat = 16'h0; sel = 2'b11;
        @(posedge clk);
        first_ack = 0; second_ack = 0; consec = 0; prev_ack = 1'b0; b2b_rd = 16'h0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ack_o && prev_ack) consec++;
            prev_ack = ack_o;
            if (ack_o && first_ack == 0) begin
                first_ack = n;
                b2b_rd    = dat_o;
                we = 1'b1; adr = 15'h111; dat = 16'hF00D; sel = 2'b11;
            end else if (ack_o && second_ack == 0) begin
                second_ack = n;
                cyc = 1'b0; stb = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        model_write(15'h111, 16'hF00D, 2'b11);
        check_val("b2b_first", 32'(first_ack), 32'(1 + WS));
        check_val("b2b_second", 32'(second_ack), 32'(2 * (1 + WS) + 1));
        check_val("b2b_consec", 32'(consec), 32'd0);
        check_val("b2b_rd", 32'(b2b_rd), 32'h0000BEEF);
        read_expect(15'h111, 16'hF00D, "b2b_wr");

        // Random traffic over a small window plus decode edges.
        edges[0] = 15'h0FF; edges[1] = 15'h100; edges[2] = 15'h4FF;
        edges[3] = 15'h500; edges[4] = 15'h7FFF; edges[5] = 15'h000;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) < 8) ra = 15'(BASE + $urandom_range(0, 31));
            else ra = edges[$urandom_range(0, 5)];
            bus(1'($urandom), ra, 16'($urandom), 2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
